md_arbiter: RTL and testbench
=============================

# md_arbiter

Round-robin arbiter and sequencer that shares one iterative multiply/divide unit (`mult_div`) between `NREQ` requesters. It accepts operand bundles over per-requester valid/ready handshakes, registers and holds the operands stable for the whole calculation, and issues the single-cycle enable pulse. It captures the result and status flags, then returns them to the originating requester over a per-requester valid/ready response channel. It sits between the issuing pipelines and the shared unit; the unit's own blocking-mode rules hold by construction.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: operand width; must match the unit.
- `C_DW`, `2*DW`: result width (derived).
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_vld_i` in NREQ: request valid, one bit per requester.
- `req_rdy_o` out NREQ: request accepted; one-hot or zero.
- `req_op_i` in NREQ: 0=MULT, 1=DIV.
- `req_tc_i` in 2*NREQ: signed mode {b,a} per requester.
- `req_a_i` / `req_b_i` in NREQ*DW: operands per requester.
- `rsp_vld_o` out NREQ: response valid; one-hot or zero.
- `rsp_rdy_i` in NREQ: response ready.
- `rsp_c_o` out C_DW: product, or {remainder, quotient}.
- `rsp_dbz_o`, `rsp_ovf_o` out 1: divide-by-zero and signed overflow flags for the response.
- `md_en_po` out 1: enable pulse to the unit.
- `md_op_o` out 1, `md_tc_o` out 2, `md_a_o`/`md_b_o` out DW: operands driven to the unit.
- `md_busy_i` in 1, `md_c_vld_i` in 1, `md_c_i` in C_DW, `md_dbz_i` in 1, `md_ovf_i` in 1: unit status and result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: round-robin grant among asserted `req_vld_i`. Priority starts at the index after the last granted requester; after reset it starts at 0.
  - `req_rdy_o[g]` is asserted combinationally for the winner only.
  - On handshake, latch op/tc/a/b and the owner index, then go to ISSUE.
- ISSUE: `md_en_po`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold the latched operands on `md_*_o`. On `md_c_vld_i`=1, capture `md_c_i`, `md_dbz_i` and `md_ovf_i`, then go to RESP.
- RESP: `rsp_vld_o[owner]`=1; the data and flags stay stable until `rsp_rdy_i[owner]`=1, then go to IDLE.
  - No new request is accepted while in ISSUE, WAIT or RESP, so at most one operation is in flight.
- `md_*_o` operand registers change only on an accepted request, which keeps the unit's inputs stable while it is busy.
- `md_busy_i` is used only for checking: `md_en_po` must never assert while `md_busy_i`=1. Violating this is a design bug.
- Pointer update: after a grant to g, the next search starts at (g+1) mod NREQ. Wrap-around is required for every NREQ, including non-powers of two.
- Requesters must not drop `req_vld_i` or change their payload before `req_rdy_o`; the arbiter takes no action if they do.

## Timing
- Reset values:
  - FSM=IDLE, pointer=0.
  - `req_rdy_o`, `rsp_vld_o`, `md_en_po`, `md_op_o`, `md_tc_o`, `md_a_o`, `md_b_o`, `rsp_c_o`, `rsp_dbz_o`, `rsp_ovf_o` = 0.
- Cycle sequence for an accepted request (handshake at cycle 0):
  - `md_en_po` at cycle 1.
  - Unit `md_c_vld_i` at cycle DW+2.
  - `rsp_vld_o` at cycle DW+3.
- If `rsp_rdy_i` is held high, the next grant can handshake at cycle DW+4, giving throughput of one operation per DW+4 cycles.
- Response latency is extended one cycle per cycle that `rsp_rdy_i` is low. The unit is idle during that time.
- Reset mid-operation: all state clears asynchronously and any in-flight result is discarded. The unit is reset by the same `rst_ni`.

## Configuration
- `MD_ARB_ZERO_BYPASS_EN` defined:
  - In IDLE, an accepted request goes directly to RESP, skipping ISSUE and WAIT, with no `md_en_po`, when it is:
    - DIV with b=0: result {remainder=a, quotient=all ones}, dbz=1, ovf=0.
    - MULT with a=0 or b=0: result 0, flags 0.
  - `rsp_vld_o` then asserts at cycle 1.
- `MD_ARB_ZERO_BYPASS_EN` undefined: every request goes through the unit, and zero operands take the full latency.

## Test plan
- Single MULT, DW=8, requester 2: a=0x0C, b=0x0A, unsigned -> `md_en_po` at cycle 1; `rsp_vld_o`=0b0100 at cycle 11; `rsp_c_o`=0x0078.
- All four requesters assert together with DIV a=100, b=7 -> grants in order 0,1,2,3. Each gets `rsp_c_o`={2,14}=0x020E. No two `md_en_po` pulses are closer than DW+4 cycles.
- Signed DIV: a=0x80, b=0xFF, tc=2'b11 -> `rsp_ovf_o`=1, `rsp_c_o`=0x0080.
- Backpressure: `rsp_rdy_i` low for 5 cycles -> `rsp_vld_o`, `rsp_c_o` and the flags stay stable. Meanwhile `req_rdy_o`=0 even though `req_vld_i` is pending, and `md_en_po` stays 0.
- DIV b=0, a=0x33:
  - Without the macro -> `rsp_dbz_o`=1 at cycle 11.
  - With the macro -> `rsp_vld_o` at cycle 1, `rsp_c_o`=0x33FF, no `md_en_po`.
- Assert `rst_ni`=0 during WAIT -> outputs are 0 immediately; after release, a new request completes normally with grant pointer 0.

Source files
------------

// File: rtl/md_arbiter.sv
// md_arbiter: round-robin arbiter and sequencer that shares one iterative
// multiply/divide unit (mult_div) between NREQ requesters.
//   - Requests are accepted over per-requester valid/ready handshakes.
//   - The winner's operands are registered and held stable for the unit.
//   - The result goes back to the originating requester over a
//     per-requester valid/ready response channel.
// Optional feature macro: MD_ARB_ZERO_BYPASS_EN. When it is defined, trivial
// zero-operand requests are answered directly and never reach the unit.
module md_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int C_DW = 2 * DW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_vld_i,
  output logic [NREQ-1:0]      req_rdy_o,
  input  logic [NREQ-1:0]      req_op_i,
  input  logic [2*NREQ-1:0]    req_tc_i,
  input  logic [NREQ*DW-1:0]   req_a_i,
  input  logic [NREQ*DW-1:0]   req_b_i,
  output logic [NREQ-1:0]      rsp_vld_o,
  input  logic [NREQ-1:0]      rsp_rdy_i,
  output logic [C_DW-1:0]      rsp_c_o,
  output logic                 rsp_dbz_o,
  output logic                 rsp_ovf_o,
  output logic                 md_en_po,
  output logic                 md_op_o,
  output logic [1:0]           md_tc_o,
  output logic [DW-1:0]        md_a_o,
  output logic [DW-1:0]        md_b_o,
  input  logic                 md_busy_i,
  input  logic                 md_c_vld_i,
  input  logic [C_DW-1:0]      md_c_i,
  input  logic                 md_dbz_i,
  input  logic                 md_ovf_i
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q;      // first index searched in the next arbitration
  logic [IW-1:0]   owner_q;    // requester that owns the operation in flight
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            req_fire;
  logic            bypass;
  logic            res_cap;
  logic            sel_op;
  logic [1:0]      sel_tc;
  logic [DW-1:0]   sel_a, sel_b;
  logic [C_DW-1:0] res_c;
  logic            res_dbz, res_ovf;

  // Round-robin search. It starts at ptr_q and wraps explicitly, so the
  // search is also correct when NREQ is not a power of two.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    int            cand;
    logic [IW-1:0] cand_idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = cand[IW-1:0];
      if (!gnt_found && req_vld_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // The ready is one-hot for the winner and only asserts in IDLE. It is also
  // held off while in reset, because the registers cannot capture a handshake.
  always_comb begin
    req_rdy_o = '0;
    if (rst_ni && state_q == IDLE && gnt_found) req_rdy_o[gnt_idx] = 1'b1;
  end

  assign req_fire = (state_q == IDLE) && gnt_found;
  assign sel_op   = req_op_i[gnt_idx];
  assign sel_tc   = req_tc_i[int'(gnt_idx) * 2 +: 2];
  assign sel_a    = req_a_i[int'(gnt_idx) * DW +: DW];
  assign sel_b    = req_b_i[int'(gnt_idx) * DW +: DW];

`ifdef MD_ARB_ZERO_BYPASS_EN
  // Zero operands have a known answer, so those requests skip the unit.
  assign bypass = sel_op ? (sel_b == '0) : ((sel_a == '0) || (sel_b == '0));
`else
  assign bypass = 1'b0;
`endif

  // Result source. Normally this is the unit. A bypassed request instead
  // uses the fixed zero-operand answer.
  always_comb begin
    res_c   = md_c_i;
    res_dbz = md_dbz_i;
    res_ovf = md_ovf_i;
`ifdef MD_ARB_ZERO_BYPASS_EN
    if (state_q == IDLE) begin
      res_c   = sel_op ? {sel_a, {DW{1'b1}}} : '0;
      res_dbz = sel_op;
      res_ovf = 1'b0;
    end
`endif
  end

  assign res_cap = ((state_q == WAIT) && md_c_vld_i) || (req_fire && bypass);

  // Sequencer next-state logic and the per-state outputs.
  always_comb begin
    state_d   = state_q;
    md_en_po  = 1'b0;
    rsp_vld_o = '0;
    unique case (state_q)
      IDLE:  if (req_fire) state_d = bypass ? RESP : ISSUE;
      ISSUE: begin
        md_en_po = 1'b1;
        state_d  = WAIT;
      end
      WAIT:  if (md_c_vld_i) state_d = RESP;
      RESP: begin
        rsp_vld_o[owner_q] = 1'b1;
        if (rsp_rdy_i[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration pointer and owner registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge no matter what order the code is in.
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        owner_q <= gnt_idx;
        ptr_q   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Operand registers load only on an accepted request. This keeps the
  // unit's inputs stable for the whole calculation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      md_op_o <= 1'b0;
      md_tc_o <= '0;
      md_a_o  <= '0;
      md_b_o  <= '0;
    end else if (req_fire) begin
      md_op_o <= sel_op;
      md_tc_o <= sel_tc;
      md_a_o  <= sel_a;
      md_b_o  <= sel_b;
    end
  end

  // Response registers hold the result until the owner accepts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_c_o   <= '0;
      rsp_dbz_o <= 1'b0;
      rsp_ovf_o <= 1'b0;
    end else if (res_cap) begin
      rsp_c_o   <= res_c;
      rsp_dbz_o <= res_dbz;
      rsp_ovf_o <= res_ovf;
    end
  end

  // The shared unit must never be started while it is still busy.
  a_no_en_while_busy: assert property (
    @(posedge clk_i) disable iff (!rst_ni) md_en_po |-> !md_busy_i);

endmodule

// File: tb/tb_md_arbiter.sv
// tb_md_arbiter: self-checking bench for md_arbiter.
// - A behavioural stand-in for the mult_div unit answers DW+1 cycles after
//   each enable pulse.
// - A transaction-level reference model predicts the round-robin grant
//   order, the latency and the arithmetic result of every operation.
// - Honours MD_ARB_ZERO_BYPASS_EN when it is defined.
module tb_md_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int C_DW = 2 * DW;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NREQ-1:0]     req_vld_i, req_rdy_o, req_op_i, rsp_vld_o, rsp_rdy_i;
  logic [2*NREQ-1:0]   req_tc_i;
  logic [NREQ*DW-1:0]  req_a_i, req_b_i;
  logic [C_DW-1:0]     rsp_c_o, md_c_i;
  logic                rsp_dbz_o, rsp_ovf_o, md_en_po, md_op_o;
  logic [1:0]          md_tc_o;
  logic [DW-1:0]       md_a_o, md_b_o;
  logic                md_busy_i, md_c_vld_i, md_dbz_i, md_ovf_i;

  md_arbiter #(.NREQ(NREQ), .DW(DW), .C_DW(C_DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_op_i(req_op_i),
    .req_tc_i(req_tc_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_c_o(rsp_c_o),
    .rsp_dbz_o(rsp_dbz_o), .rsp_ovf_o(rsp_ovf_o),
    .md_en_po(md_en_po), .md_op_o(md_op_o), .md_tc_o(md_tc_o),
    .md_a_o(md_a_o), .md_b_o(md_b_o), .md_busy_i(md_busy_i),
    .md_c_vld_i(md_c_vld_i), .md_c_i(md_c_i), .md_dbz_i(md_dbz_i),
    .md_ovf_i(md_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [C_DW-1:0] c;
    logic            dbz;
    logic            ovf;
  } res_t;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side pending requests: each one is held until it is granted.
  logic          pend_vld [NREQ];
  logic          pend_op  [NREQ];
  logic [1:0]    pend_tc  [NREQ];
  logic [DW-1:0] pend_a   [NREQ];
  logic [DW-1:0] pend_b   [NREQ];

  int              ref_ptr;
  int              cyc;
  int              unit_cnt;
  int              last_en;
  int              last_w;
  logic [C_DW-1:0] last_c;
  logic            last_dbz, last_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: operands are extended to integers according to
  // their tc bit, then the result is taken from plain SV arithmetic.
  function automatic res_t ref_calc(input logic op, input logic [1:0] tc,
                                    input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa, sb, p, q, r;
    res_t   res;
    sa = longint'(a);
    sb = longint'(b);
    if (tc[0] && a[DW-1]) sa = sa - (longint'(1) << DW);
    if (tc[1] && b[DW-1]) sb = sb - (longint'(1) << DW);
    res = '0;
    if (!op) begin
      p = sa * sb;
      res.c = p[C_DW-1:0];
    end else if (b == '0) begin
      res.c   = {a, {DW{1'b1}}};
      res.dbz = 1'b1;
    end else if (tc == 2'b11 && a == {1'b1, {(DW-1){1'b0}}} && b == '1) begin
      res.c   = {{DW{1'b0}}, a};
      res.ovf = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      res.c = {r[DW-1:0], q[DW-1:0]};
    end
    return res;
  endfunction

  function automatic bit is_bypass(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MD_ARB_ZERO_BYPASS_EN
    return op ? (b == '0) : ((a == '0) || (b == '0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int rr_pick();
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ref_ptr + i) % NREQ;
      if (pend_vld[k]) return k;
    end
    return 0;
  endfunction

  task automatic drive_reqs();
    for (int k = 0; k < NREQ; k++) begin
      req_vld_i[k]          = pend_vld[k];
      req_op_i[k]           = pend_op[k];
      req_tc_i[2*k +: 2]    = pend_tc[k];
      req_a_i[k*DW +: DW]   = pend_a[k];
      req_b_i[k*DW +: DW]   = pend_b[k];
    end
  endtask

  task automatic add_req(input int k, input logic op, input logic [1:0] tc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend_vld[k] = 1'b1;
    pend_op[k]  = op;
    pend_tc[k]  = tc;
    pend_a[k]   = a;
    pend_b[k]   = b;
  endtask

  // One clock cycle. The unit stand-in answers DW+1 cycles after it sees an
  // enable, using whatever operands the arbiter is presenting at that time.
  task automatic step();
    logic en_now;
    res_t r;
    en_now = md_en_po;
    @(posedge clk_i);
    #1;
    cyc++;
    if (unit_cnt > 0) unit_cnt--;
    if (en_now) unit_cnt = DW + 1;
    md_busy_i  = (unit_cnt > 1);
    md_c_vld_i = (unit_cnt == 1);
    if (unit_cnt == 1) begin
      r = ref_calc(md_op_o, md_tc_o, md_a_o, md_b_o);
      md_c_i   = r.c;
      md_dbz_i = r.dbz;
      md_ovf_i = r.ovf;
    end else begin
      md_c_i   = C_DW'($urandom);
      md_dbz_i = 1'($urandom);
      md_ovf_i = 1'($urandom);
    end
    #1;
  endtask

  // One full operation for the requester the model expects to win, with
  // 'hold' cycles of response backpressure.
  task automatic do_transaction(input int hold);
    int   w, waited, lat;
    res_t exp;
    bit   byp, quiet, stable;
    logic [C_DW-1:0] c0;
    logic d0, o0;
    w = rr_pick();
    drive_reqs();
    #1;
    waited = 0;
    while (req_rdy_o == '0 && waited < 4) begin
      step(); drive_reqs(); #1;
      waited++;
    end
    check("grant_wait", waited, 0);
    check("grant_onehot", req_rdy_o, NREQ'(1) << w);
    exp = ref_calc(pend_op[w], pend_tc[w], pend_a[w], pend_b[w]);
    byp = is_bypass(pend_op[w], pend_a[w], pend_b[w]);
    last_w = w;
    pend_vld[w] = 1'b0;
    ref_ptr = (w + 1) % NREQ;
    step(); drive_reqs(); rsp_rdy_i = NREQ'($urandom); #1;
    lat = 1;
    if (!byp) begin
      check("md_en", md_en_po, 1);
      check("md_op", md_op_o, pend_op[w]);
      check("md_tc", md_tc_o, pend_tc[w]);
      check("md_a", md_a_o, pend_a[w]);
      check("md_b", md_b_o, pend_b[w]);
      check("en_gap", (cyc - last_en) >= DW + 4, 1);
      last_en = cyc;
    end
    quiet = 1'b1;
    while (rsp_vld_o == '0 && lat < 3 * DW) begin
      step(); drive_reqs(); rsp_rdy_i = NREQ'($urandom); #1;
      lat++;
      if (md_en_po || req_rdy_o != '0) quiet = 1'b0;
    end
    check("latency", lat, byp ? 1 : DW + 3);
    check("busy_quiet", quiet, 1);
    check("rsp_vld", rsp_vld_o, NREQ'(1) << w);
    check("rsp_c", rsp_c_o, exp.c);
    check("rsp_dbz", rsp_dbz_o, exp.dbz);
    check("rsp_ovf", rsp_ovf_o, exp.ovf);
    c0 = rsp_c_o; d0 = rsp_dbz_o; o0 = rsp_ovf_o;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      rsp_rdy_i = NREQ'($urandom) & ~(NREQ'(1) << w);
      step(); drive_reqs(); #1;
      if (rsp_vld_o != (NREQ'(1) << w) || rsp_c_o != c0 || rsp_dbz_o != d0 ||
          rsp_ovf_o != o0 || req_rdy_o != '0 || md_en_po) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    last_c = rsp_c_o; last_dbz = rsp_dbz_o; last_ovf = rsp_ovf_o;
    rsp_rdy_i = NREQ'($urandom) | (NREQ'(1) << w);
    step(); rsp_rdy_i = '0; drive_reqs(); #1;
    check("rsp_done", rsp_vld_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, expected finish well before", $time);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a, b;
    rst_ni = 1'b0;
    req_vld_i = '0; req_op_i = '0; req_tc_i = '0; req_a_i = '0; req_b_i = '0;
    rsp_rdy_i = '0; md_busy_i = 1'b0; md_c_vld_i = 1'b0; md_c_i = '0;
    md_dbz_i = 1'b0; md_ovf_i = 1'b0;
    cyc = 0; unit_cnt = 0; last_en = -1000; ref_ptr = 0; last_w = 0;
    for (int k = 0; k < NREQ; k++) begin
      pend_vld[k] = 1'b0; pend_op[k] = 1'b0; pend_tc[k] = '0; pend_a[k] = '0; pend_b[k] = '0;
    end
    #1;
    check("rst_req_rdy", req_rdy_o, 0);
    check("rst_rsp_vld", rsp_vld_o, 0);
    check("rst_md_en", md_en_po, 0);
    check("rst_md_ops", {md_op_o, md_tc_o, md_a_o, md_b_o}, 0);
    check("rst_rsp", {rsp_c_o, rsp_dbz_o, rsp_ovf_o}, 0);
    step(); step();
    rst_ni = 1'b1;

    // All four requesters at once: grants go 0,1,2,3 and each result is 0x020E.
    for (int k = 0; k < NREQ; k++) add_req(k, 1'b1, 2'b00, DW'(100), DW'(7));
    for (int k = 0; k < NREQ; k++) begin
      do_transaction(0);
      check("all4_order", last_w, k);
      check("all4_c", last_c, 16'h020E);
    end

    // Single unsigned MULT on requester 2.
    add_req(2, 1'b0, 2'b00, 8'h0C, 8'h0A);
    do_transaction(0);
    check("mult_c", last_c, 16'h0078);

    // Signed DIV overflow.
    add_req(1, 1'b1, 2'b11, 8'h80, 8'hFF);
    do_transaction(0);
    check("ovf_flag", last_ovf, 1);
    check("ovf_c", last_c, 16'h0080);

    // Backpressure with other requesters pending.
    add_req(0, 1'b0, 2'b01, 8'hF3, 8'h05);
    add_req(3, 1'b1, 2'b00, 8'hC8, 8'h0B);
    do_transaction(5);
    do_transaction(2);

    // Divide by zero.
    add_req(2, 1'b1, 2'b00, 8'h33, 8'h00);
    do_transaction(0);
    check("dbz_flag", last_dbz, 1);
    check("dbz_c", last_c, 16'h33FF);

    // Reset while waiting for the unit.
    add_req(2, 1'b1, 2'b01, 8'h55, 8'h03);
    drive_reqs(); #1;
    check("rst_mid_grant", req_rdy_o, 4'b0100);
    pend_vld[2] = 1'b0;
    step(); drive_reqs(); #1;
    check("rst_mid_en", md_en_po, 1);
    step(); step(); step();
    rst_ni = 1'b0;
    #1;
    check("rst_mid_req_rdy", req_rdy_o, 0);
    check("rst_mid_rsp_vld", rsp_vld_o, 0);
    check("rst_mid_md_en", md_en_po, 0);
    check("rst_mid_md_ops", {md_op_o, md_tc_o, md_a_o, md_b_o}, 0);
    check("rst_mid_rsp", {rsp_c_o, rsp_dbz_o, rsp_ovf_o}, 0);
    unit_cnt = 0; md_c_vld_i = 1'b0; md_busy_i = 1'b0;
    ref_ptr = 0; last_en = -1000;
    step(); step();
    rst_ni = 1'b1;
    add_req(1, 1'b0, 2'b10, 8'h07, 8'hFE);
    add_req(3, 1'b1, 2'b10, 8'h64, 8'hF9);
    do_transaction(0);
    check("post_rst_first", last_w, 1);
    do_transaction(1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit any;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend_vld[k] && $urandom_range(0, 1) == 1) begin
          a = DW'($urandom);
          b = DW'($urandom);
          case ($urandom_range(0, 7))
            0: a = '0;
            1: b = '0;
            2: begin a = {1'b1, {(DW-1){1'b0}}}; b = '1; end
            default: ;
          endcase
          add_req(k, 1'($urandom), 2'($urandom), a, b);
        end
        if (pend_vld[k]) any = 1'b1;
      end
      if (!any) add_req(int'($urandom_range(0, NREQ - 1)), 1'($urandom), 2'($urandom),
                        DW'($urandom), DW'($urandom));
      do_transaction(int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
